// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder: one digit pair per clock, least significant digit first.
// Optional invalid-digit flag is built only when BCD_DIGIT_CHECK_EN is defined.
//
// state | meaning
// IDLE  | waiting for start; sum/c_out/err hold last result
// ADD   | processing digit k, carry registered between digits
// DONE  | result valid, one-cycle done pulse
module bcd_serial_adder #(
    parameter int DIGITS = 2
) (
    input  logic                  CLK_50,
    input  logic                  RST,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  c_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  c_out,
    output logic                  err
);

    localparam int KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADD  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]          state;
    logic [4*DIGITS-1:0] a_q;
    logic [4*DIGITS-1:0] b_q;
    logic                carry;
    logic [KW-1:0]       k;

    logic [3:0] a_k;
    logic [3:0] b_k;
    logic [4:0] t;
    logic [4:0] t_adj;
    logic [3:0] digit;
    logic       carry_nxt;
    logic       last_digit;

    // t may reach 31 with invalid digits; only the low nibble of t+6 is kept
    always_comb begin
        a_k        = a_q[k*4 +: 4];
        b_k        = b_q[k*4 +: 4];
        t          = {1'b0, a_k} + {1'b0, b_k} + {4'd0, carry};
        t_adj      = t + 5'd6;
        digit      = t[3:0];
        carry_nxt  = 1'b0;
        if (t > 5'd9) begin
            digit     = t_adj[3:0];
            carry_nxt = 1'b1;
        end
        last_digit = (k == KW'(DIGITS - 1));
    end

    always_ff @(posedge CLK_50) begin
        if (RST) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            carry <= 1'b0;
            k     <= '0;
            sum   <= '0;
            c_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        carry <= c_in;
                        k     <= '0;
                        sum   <= '0;
                        state <= ADD;
                    end
                end
                ADD: begin
                    sum[k*4 +: 4] <= digit;
                    carry         <= carry_nxt;
                    if (last_digit) begin
                        c_out <= carry_nxt;
                        state <= DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == ADD);
    assign done = (state == DONE);

`ifdef BCD_DIGIT_CHECK_EN
    logic err_q;

    always_ff @(posedge CLK_50) begin
        if (RST) begin
            err_q <= 1'b0;
        end else if (state == IDLE && start) begin
            err_q <= 1'b0;
        end else if (state == ADD && (a_k > 4'd9 || b_k > 4'd9)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Scoreboard bench for bcd_serial_adder: 2-digit DUT checked against a digit-wise
// decimal model, plus a 4-digit instance for parameterisation.
module tb_bcd_serial_adder;

    logic        CLK_50 = 1'b0;
    logic        RST    = 1'b1;
    logic        start  = 1'b0;
    logic [7:0]  a      = '0;
    logic [7:0]  b      = '0;
    logic        c_in   = 1'b0;
    logic        busy;
    logic        done;
    logic [7:0]  sum;
    logic        c_out;
    logic        err;

    logic        start4 = 1'b0;
    logic [15:0] a4     = '0;
    logic [15:0] b4     = '0;
    logic        c_in4  = 1'b0;
    logic        busy4;
    logic        done4;
    logic [15:0] sum4;
    logic        c_out4;
    logic        err4;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [17:0] exp_q[$];
    logic [17:0] last_exp;

    bcd_serial_adder #(.DIGITS(2)) u_dut (
        .CLK_50(CLK_50), .RST(RST), .start(start), .a(a), .b(b), .c_in(c_in),
        .busy(busy), .done(done), .sum(sum), .c_out(c_out), .err(err)
    );

    bcd_serial_adder #(.DIGITS(4)) u_dut4 (
        .CLK_50(CLK_50), .RST(RST), .start(start4), .a(a4), .b(b4), .c_in(c_in4),
        .busy(busy4), .done(done4), .sum(sum4), .c_out(c_out4), .err(err4)
    );

    always #10 CLK_50 = ~CLK_50;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    // returns {err, c_out, sum[15:0]} for an n-digit add
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic c, input int n);
        int          cy;
        int          t;
        int          dx;
        int          dy;
        logic [15:0] s;
        logic        bad;
        cy  = int'(c);
        s   = '0;
        bad = 1'b0;
        for (int i = 0; i < n; i++) begin
            dx = int'((x >> (4 * i)) & 16'hF);
            dy = int'((y >> (4 * i)) & 16'hF);
            if (dx > 9 || dy > 9) bad = 1'b1;
            t = dx + dy + cy;
            if (t > 9) begin
                t  = (t + 6) % 16;
                cy = 1;
            end else begin
                cy = 0;
            end
            s = s | (16'(t) << (4 * i));
        end
`ifndef BCD_DIGIT_CHECK_EN
        bad = 1'b0;
`endif
        return {bad, cy[0], s};
    endfunction

    always @(negedge CLK_50) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                logic [17:0] e;
                e = exp_q.pop_front();
                check("sum", 32'(sum), 32'(e[7:0]));
                check("c_out", 32'(c_out), 32'(e[16]));
                check("err", 32'(err), 32'(e[17]));
            end
        end
    end

    // issue one operation; optionally poke start again while busy
    task automatic do_op(input logic [7:0] x, input logic [7:0] y, input logic c,
                         input logic poke);
        int cyc;
        @(negedge CLK_50);
        a = x; b = y; c_in = c; start = 1'b1;
        last_exp = model({8'h00, x}, {8'h00, y}, c, 2);
        exp_q.push_back(last_exp);
        @(negedge CLK_50);
        start = 1'b0;
        if (poke) begin
            a = 8'h11; b = 8'h11; start = 1'b1;
        end
        cyc = 1;
        while (!done && cyc < 20) begin
            check("busy_during_add", 32'(busy), 32'd1);
            @(negedge CLK_50);
            start = 1'b0;
            cyc++;
        end
        check("done_latency", 32'(cyc), 32'd3);
        check("busy_at_done", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [7:0] rx;
        logic [7:0] ry;
        logic [17:0] e4;
        int cyc;

        repeat (2) @(negedge CLK_50);
        RST = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_c_out", 32'(c_out), 32'd0);
        check("rst_err", 32'(err), 32'd0);

        do_op(8'h45, 8'h37, 1'b0, 1'b0);
        check("basic_model", 32'(last_exp[8:0]), 32'h082);
        do_op(8'h99, 8'h99, 1'b1, 1'b0);
        do_op(8'h00, 8'h00, 1'b0, 1'b0);
        do_op(8'h45, 8'h37, 1'b0, 1'b1);
        do_op(8'hA5, 8'h01, 1'b0, 1'b0);

        // hold after done with changed inputs
        @(negedge CLK_50);
        a = 8'h77; b = 8'h66; c_in = 1'b1;
        repeat (3) @(negedge CLK_50);
        check("hold_sum", 32'(sum), 32'(last_exp[7:0]));
        check("hold_c_out", 32'(c_out), 32'(last_exp[16]));
        check("hold_err", 32'(err), 32'(last_exp[17]));

        // reset on first ADD cycle
        @(negedge CLK_50);
        a = 8'h99; b = 8'h99; c_in = 1'b1; start = 1'b1;
        @(negedge CLK_50);
        start = 1'b0; RST = 1'b1;
        @(negedge CLK_50);
        RST = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_c_out", 32'(c_out), 32'd0);
        do_op(8'h12, 8'h29, 1'b1, 1'b0);

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                rx = 8'($urandom);
                ry = 8'($urandom);
            end else begin
                rx = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
                ry = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            end
            do_op(rx, ry, 1'($urandom), 1'($urandom_range(0, 1)));
        end

        // four-digit instance
        @(negedge CLK_50);
        a4 = 16'h1234; b4 = 16'h8766; c_in4 = 1'b0; start4 = 1'b1;
        e4 = model(16'h1234, 16'h8766, 1'b0, 4);
        @(negedge CLK_50);
        start4 = 1'b0;
        cyc = 1;
        while (!done4 && cyc < 30) begin
            check("busy4", 32'(busy4), 32'd1);
            @(negedge CLK_50);
            cyc++;
        end
        check("done4_latency", 32'(cyc), 32'd5);
        check("sum4", 32'(sum4), 32'(e4[15:0]));
        check("c_out4", 32'(c_out4), 32'(e4[16]));
        check("sum4_known", 32'(sum4), 32'h0000);

        repeat (4) @(negedge CLK_50);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/bcd_serial_adder.md
Name: bcd_serial_adder

Overview:
- Digit-serial multi-digit BCD adder that extends the single-digit BCD adder stage to DIGITS-digit operands.
- Operands are loaded in parallel. One BCD digit pair is added per clock, least significant digit first, through a registered decimal carry.
- Packed BCD sum and carry-out feed the two-digit HEX display stage (sum as {tens, ones} nibbles) and the LEDs.

Parameters:
- DIGITS, 2, number of BCD digits per operand (>=1); operand and sum width = 4*DIGITS.

Ports:
- CLK_50  in  1  system clock, all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- a  in  4*DIGITS  operand A, packed BCD, digit 0 = bits [3:0].
- b  in  4*DIGITS  operand B, packed BCD.
- c_in  in  1  decimal carry into digit 0.
- busy  out  1  high while digits are being processed.
- done  out  1  one-cycle pulse, result valid.
- sum  out  4*DIGITS  packed BCD result.
- c_out  out  1  decimal carry out of the most significant digit.
- err  out  1  invalid-digit flag (see Optional Feature).

Behaviour:
- One clock (CLK_50). Reset is synchronous and active-high (RST).
- Reset:
  - state=IDLE.
  - busy=0, done=0, sum=0, c_out=0, err=0.
  - Internal operand copies, carry and digit counter are cleared.
- FSM states: IDLE, ADD, DONE.
- IDLE:
  - On an edge with start=1: latch a, b, c_in into internal registers, clear counter k=0, clear sum and err, go to ADD.
  - start=0: remain in IDLE; sum, c_out, err hold their last values.
- ADD:
  - busy=1.
  - Each edge processes digit k: t = a_k + b_k + carry (5-bit, range 0..19 for valid digits).
  - If t > 9: digit = (t + 6)[3:0], carry = 1.
  - Else: digit = t[3:0], carry = 0.
  - The digit is written into sum nibble k; k increments.
  - After digit DIGITS-1 is written, c_out takes the final carry and the FSM goes to DONE.
- DONE:
  - busy=0, done=1 for exactly one cycle, then IDLE.
- Latency: start is sampled at edge E0. Digit k is written at edge E0+k+1. done is high in the cycle after edge E0+DIGITS. For DIGITS=2, done is visible during cycle 3 after start.
- sum and c_out are registered. They are partially updated during ADD and are stable from DONE until the next accepted start.
- start while in ADD or DONE is ignored (no queuing). start held high re-triggers on the first IDLE cycle.
- Inputs a, b, c_in may change freely after acceptance; only the latched copies are used.
- RST during ADD aborts immediately: all outputs return to reset values, and done is not asserted.
- Carry chain is decimal only; no binary overflow is exposed. Maximum result (all 9s + all 9s + 1) gives sum = all 9s, c_out = 1.
- Invalid digits (>9) are not corrected on input. The same t rule is applied, so the t range extends to 31, and only bits [3:0] of (t+6) are kept.

Optional Feature:
- Macro: BCD_DIGIT_CHECK_EN.
- Defined:
  - err is cleared on start.
  - err is set sticky if any latched digit of a or b is greater than 9 as it is processed in ADD.
  - err is valid with done and holds until the next start.
- Not defined:
  - err is driven constant 0.
  - No comparison logic is built.
- Arithmetic results are identical in both builds.

Test Plan:
- Basic sum: RST 1 cycle, then a=0x45, b=0x37, c_in=0, start 1 cycle -> busy high 2 cycles, done pulse in 3rd cycle, sum=0x82, c_out=0, err=0.
- Maximum result: a=0x99, b=0x99, c_in=1 -> sum=0x99, c_out=1. Then a=0x00, b=0x00, c_in=0 -> sum=0x00, c_out=0.
- Start while busy: start again during ADD with a=0x11, b=0x11 -> ignored; first result 0x82 completes unchanged, and only one done pulse occurs.
- Reset mid-operation: RST asserted on the 1st ADD cycle -> next cycle busy=0, done=0, sum=0, c_out=0. A new start then completes normally.
- Invalid digit: a=0xA5, b=0x01, c_in=0 -> sum=0x06, c_out=1. With BCD_DIGIT_CHECK_EN, err=1 at done. Without the macro, err=0.
- Hold and parameterisation: after done, change a and b with start=0 -> sum, c_out, err unchanged. With DIGITS=4, a=0x1234, b=0x8766 -> done after 4 busy cycles, sum=0x0000, c_out=1.
